// File: rtl/decrypter_out_if.sv
// Bundle of the session-control, packet-input and UART-output signals around decrypter_out.
// The slave modport is the block itself; the master modport is whatever drives and observes it.
interface decrypter_out_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [5:0]        n_len;
    logic              pkt_ready;
    logic              fme_done;
    logic [DATA_W-1:0] fme_data_out;
    logic              pkt_last;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              done;

    modport slave (
        input  start, n_len, fme_done, fme_data_out, pkt_last, tx_busy,
        output pkt_ready, tx_start, tx_data, done
    );

    modport master (
        output start, n_len, fme_done, fme_data_out, pkt_last, tx_busy,
        input  pkt_ready, tx_start, tx_data, done
    );
endinterface

// File: rtl/decrypter_out.sv
// Unpacks (n_len-1)-bit decrypted packets into an LSB-first byte stream and hands each
// completed byte to a UART transmitter; bytes may straddle packet boundaries.
module decrypter_out #(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    decrypter_out_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, WAIT_PKT, UNPACK, SEND, HOLD} state_t;

    state_t            state;
    logic [DATA_W-1:0] pack;
    logic [7:0]        acc;
    logic [2:0]        bcnt;
    logic [5:0]        pcnt;
    logic [5:0]        plen;
    logic              last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pack          <= '0;
            acc           <= '0;
            bcnt          <= '0;
            pcnt          <= '0;
            plen          <= '0;
            last          <= 1'b0;
            bus.pkt_ready <= 1'b0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.n_len >= 6'd2) begin
                            plen          <= bus.n_len - 6'd1;
                            acc           <= '0;
                            bcnt          <= '0;
                            pcnt          <= '0;
                            bus.pkt_ready <= 1'b1;
                            state         <= WAIT_PKT;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                WAIT_PKT: begin
                    if (bus.fme_done) begin
                        pack          <= bus.fme_data_out;
                        last          <= bus.pkt_last;
                        pcnt          <= '0;
                        bus.pkt_ready <= 1'b0;
                        state         <= UNPACK;
                    end
                end
                UNPACK: begin
                    acc  <= {pack[0], acc[7:1]};
                    pack <= pack >> 1;
                    bcnt <= bcnt + 3'd1;
                    pcnt <= pcnt + 6'd1;
                    // A completed byte always goes out first; packet exhaustion is then resolved in HOLD.
                    if (bcnt == 3'd7) begin
                        state <= SEND;
                    end else if (pcnt == plen - 6'd1) begin
                        if (last) begin
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bus.pkt_ready <= 1'b1;
                            state         <= WAIT_PKT;
                        end
                    end
                end
                SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= acc;
                        bus.tx_start <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    // One dead cycle lets the transmitter raise tx_busy before the next byte can be offered.
                    if (pcnt == plen) begin
                        if (last) begin
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bus.pkt_ready <= 1'b1;
                            state         <= WAIT_PKT;
                        end
                    end else begin
                        state <= UNPACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypter_out.sv
// Directed bench for decrypter_out: table of packet sessions with hand-packed byte streams,
// plus hand-written sequences for reset, short n_len and transmitter back-pressure.
module tb_decrypter_out;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decrypter_out_if bus ();

    decrypter_out dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [5:0]       n_len;
        logic [7:0]       npk;
        logic [7:0][31:0] pkt;
        logic [7:0]       lst;
        logic [7:0]       nexp;
        logic [7:0][7:0]  exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] txq[$];
    int         txc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;

    // Record every tx_start / done pulse with the index of the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (bus.tx_start === 1'b1) begin
            txq.push_back(bus.tx_data);
            txc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (bus.pkt_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, bus.pkt_ready}, 32'd1);
    endtask

    task automatic wait_done(input int d0, input string name);
        int k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(name, done_cnt, d0 + 1);
    endtask

    task automatic send_pkt(input logic [31:0] data, input logic lst, output int edge_idx);
        bus.fme_done     = 1'b1;
        bus.fme_data_out = data;
        bus.pkt_last     = lst;
        edge_idx         = cyc + 1;
        @(negedge clk);
        bus.fme_done     = 1'b0;
    endtask

    task automatic start_session(input logic [5:0] nl);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n_len = nl;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0 = done_cnt;
        int first_edge = 0;
        int e;
        txq.delete();
        txc.delete();
        start_session(v.n_len);
        for (int p = 0; p < int'(v.npk); p++) begin
            wait_ready($sformatf("v%0d pkt_ready%0d", idx, p));
            send_pkt(v.pkt[p], v.lst[p], e);
            if (p == 0) first_edge = e;
        end
        wait_done(d0, $sformatf("v%0d done", idx));
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d done_count", idx), done_cnt, d0 + 1);
        chk($sformatf("v%0d tx_count", idx), txq.size(), int'(v.nexp));
        for (int i = 0; i < int'(v.nexp); i++)
            chk($sformatf("v%0d byte%0d", idx, i),
                (i < txq.size()) ? {24'd0, txq[i]} : 32'hFFFF_FFFF, {24'd0, v.exp[i]});
        if (idx == 0) begin
            chk("v0 tx_latency", (txc.size() > 0) ? txc[0] - first_edge : -1, 9);
            chk("v0 done_after_hold", (txc.size() > 0) ? done_cyc - txc[0] : -1, 1);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int d0;
        int e;

        bus.start        = 1'b0;
        bus.n_len        = '0;
        bus.fme_done     = 1'b0;
        bus.fme_data_out = '0;
        bus.pkt_last     = 1'b0;
        bus.tx_busy      = 1'b0;

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        // single 8-bit packet
        vecs[0].n_len = 6'd9;  vecs[0].npk = 8'd1;
        vecs[0].pkt[0] = 32'h41; vecs[0].lst[0] = 1'b1;
        vecs[0].nexp = 8'd1; vecs[0].exp[0] = 8'h41;
        // 12-bit packets, middle byte straddles the boundary
        vecs[1].n_len = 6'd13; vecs[1].npk = 8'd2;
        vecs[1].pkt[0] = 32'h241; vecs[1].lst[0] = 1'b0;
        vecs[1].pkt[1] = 32'h434; vecs[1].lst[1] = 1'b1;
        vecs[1].nexp = 8'd3;
        vecs[1].exp[0] = 8'h41; vecs[1].exp[1] = 8'h42; vecs[1].exp[2] = 8'h43;
        // final packet with 4 residual padding bits
        vecs[2].n_len = 6'd13; vecs[2].npk = 8'd1;
        vecs[2].pkt[0] = 32'h241; vecs[2].lst[0] = 1'b1;
        vecs[2].nexp = 8'd1; vecs[2].exp[0] = 8'h41;
        // 31-bit packets: bytes 11 22 33 C4 55 66 77, six padding ones, bit 31 of pkt0 unused
        vecs[3].n_len = 6'd32; vecs[3].npk = 8'd2;
        vecs[3].pkt[0] = 32'hC433_2211; vecs[3].lst[0] = 1'b0;
        vecs[3].pkt[1] = 32'h7EEE_CCAB; vecs[3].lst[1] = 1'b1;
        vecs[3].nexp = 8'd7;
        vecs[3].exp[0] = 8'h11; vecs[3].exp[1] = 8'h22; vecs[3].exp[2] = 8'h33;
        vecs[3].exp[3] = 8'hC4; vecs[3].exp[4] = 8'h55; vecs[3].exp[5] = 8'h66;
        vecs[3].exp[6] = 8'h77;
        // n_len=2: one payload bit per packet, bit 1 of each packet must be ignored; 0xA5 LSB-first
        vecs[4].n_len = 6'd2; vecs[4].npk = 8'd8;
        vecs[4].pkt[0] = 32'h3; vecs[4].pkt[1] = 32'h2; vecs[4].pkt[2] = 32'h3; vecs[4].pkt[3] = 32'h2;
        vecs[4].pkt[4] = 32'h2; vecs[4].pkt[5] = 32'h3; vecs[4].pkt[6] = 32'h2; vecs[4].pkt[7] = 32'h3;
        vecs[4].lst = 8'h80;
        vecs[4].nexp = 8'd1; vecs[4].exp[0] = 8'hA5;
        // session after a mid-unpack reset
        vecs[5].n_len = 6'd9; vecs[5].npk = 8'd1;
        vecs[5].pkt[0] = 32'h5A; vecs[5].lst[0] = 1'b1;
        vecs[5].nexp = 8'd1; vecs[5].exp[0] = 8'h5A;

        repeat (3) @(negedge clk);
        chk("reset pkt_ready", {31'd0, bus.pkt_ready}, 32'd0);
        chk("reset tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset tx_data", {24'd0, bus.tx_data}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // n_len below 2: done next cycle, no session
        for (int nl = 0; nl < 2; nl++) begin
            d0 = done_cnt;
            txq.delete();
            start_session(nl[5:0]);
            chk($sformatf("nlen%0d done_pulse", nl), {31'd0, bus.done}, 32'd1);
            chk($sformatf("nlen%0d pkt_ready", nl), {31'd0, bus.pkt_ready}, 32'd0);
            @(negedge clk);
            chk($sformatf("nlen%0d done_low", nl), {31'd0, bus.done}, 32'd0);
            repeat (5) @(negedge clk);
            chk($sformatf("nlen%0d no_tx", nl), txq.size(), 0);
            chk($sformatf("nlen%0d done_count", nl), done_cnt, d0 + 1);
        end

        // transmitter busy: byte held in SEND, previous tx_data kept, stray start ignored
        bus.tx_busy = 1'b1;
        d0 = done_cnt;
        txq.delete();
        start_session(6'd9);
        wait_ready("busy pkt_ready");
        send_pkt(32'h3C, 1'b1, e);
        repeat (12) @(negedge clk);
        bus.start = 1'b1;
        bus.n_len = 6'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy no_tx", txq.size(), 0);
        chk("busy tx_data_held", {24'd0, bus.tx_data}, 32'hA5);
        chk("busy no_done", done_cnt, d0);
        bus.tx_busy = 1'b0;
        wait_done(d0, "busy done");
        repeat (5) @(negedge clk);
        chk("busy tx_count", txq.size(), 1);
        chk("busy byte", (txq.size() > 0) ? {24'd0, txq[0]} : 32'hFFFF_FFFF, 32'h3C);
        chk("busy stray_start_ignored", {31'd0, bus.pkt_ready}, 32'd0);

        // reset in the middle of unpacking
        d0 = done_cnt;
        txq.delete();
        start_session(6'd9);
        wait_ready("rst pkt_ready");
        send_pkt(32'hFF, 1'b1, e);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst pkt_ready", {31'd0, bus.pkt_ready}, 32'd0);
        chk("rst tx_start", {31'd0, bus.tx_start}, 32'd0);
        repeat (15) @(negedge clk);
        chk("rst no_tx", txq.size(), 0);
        chk("rst no_done", done_cnt, d0);
        run_vec(vecs[5], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
